// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and defaults for the pipeline interlock.
//   REG_W_DEF    register-address width of the core
//   LOAD_LAT_DEF default load-to-use latency in cycles
//   slot_t       one issue-history entry {valid, wr_reg, is_load}
//   slot_lat()   cycles a slot's result stays unavailable to an EX consumer
package hazard_pkg;

   localparam int unsigned REG_W_DEF    = 5;
   localparam int unsigned LOAD_LAT_DEF = 1;

   typedef struct packed {
      logic                 valid;
      logic [REG_W_DEF-1:0] wr_reg;
      logic                 is_load;
   } slot_t;

   // Only loads carry a latency; ALU results forward straight into EX.
   function automatic int unsigned slot_lat(input slot_t s, input int unsigned load_lat);
      return s.is_load ? load_lat : 32'd0;
   endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: issue-history shift register beside the ID stage.
//   clk, rst  clock, asynchronous active-high reset
//   freeze    hold every slot (data memory stall)
//   kill      invalidate every slot at the next edge; beats freeze and insert
//   ins       entry entering EX this edge (valid=0 for a bubble)
//   slots     slots[i] is the instruction i stages past EX entry
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int unsigned LOAD_LAT = LOAD_LAT_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 freeze,
   input  logic                 kill,
   input  slot_t                ins,
   output slot_t [LOAD_LAT:0]   slots
);

   // Oldest slot falls off the top; the new entry lands in slot 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slots <= '0;
      end else if (kill) begin
         slots <= '0;
      end else if (!freeze) begin
         slots <= {slots[LOAD_LAT-1:0], ins};
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / branch-operand interlock with freeze and kill.
//   Parameters: REG_W (register-address width, must match the package width),
//               LOAD_LAT (>=1, load result latency into EX), CNT_W (counter width)
//   Inputs : clk, rst (async, active-high), ID instruction description
//            (id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_branch,
//            id_wr_en, id_wr_reg, id_mem_rd), dmem_busy, pipe_kill
//   Outputs: stall_pc/stall_ifid (hold PC and IF/ID), flush_idex (bubble into
//            ID/EX), freeze (hold all pipeline registers), stall_cnt
//            (saturating count of interlock cycles). All outputs except
//            stall_cnt are combinational from inputs and scoreboard state.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned REG_W    = REG_W_DEF,
   parameter int unsigned LOAD_LAT = LOAD_LAT_DEF,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             id_branch,
   input  logic             id_wr_en,
   input  logic [REG_W-1:0] id_wr_reg,
   input  logic             id_mem_rd,
   input  logic             dmem_busy,
   input  logic             pipe_kill,
   output logic             stall_pc,
   output logic             stall_ifid,
   output logic             flush_idex,
   output logic             freeze,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int unsigned NSLOT = LOAD_LAT + 1;

   slot_t [LOAD_LAT:0] slots;
   slot_t              ins;
   logic               use_stall;
   logic               br_stall;
   logic               hazard;

   // Compare ID sources against every in-flight writer still inside its window.
   always_comb begin
      use_stall = 1'b0;
      br_stall  = 1'b0;
      for (int unsigned i = 0; i < NSLOT; i++) begin
         logic        hit;
         int unsigned lat;
         hit = slots[i].valid && (slots[i].wr_reg != '0) &&
               ((id_use_rs && (slots[i].wr_reg == REG_W_DEF'(id_rs))) ||
                (id_use_rt && (slots[i].wr_reg == REG_W_DEF'(id_rt))));
         lat = slot_lat(slots[i], LOAD_LAT);
         // A branch reads its operands one stage earlier, so its window is one wider.
         if (hit && !id_branch && (i < lat))
            use_stall = 1'b1;
         if (hit && id_branch && (i < lat + 1))
            br_stall = 1'b1;
      end
   end

   assign hazard     = id_valid & (use_stall | br_stall);
   assign freeze     = dmem_busy;
   assign stall_pc   = hazard;
   assign stall_ifid = hazard;
   assign flush_idex = hazard & ~freeze;

   // Only real register writers enter history; r0 writes are architecturally dead.
   always_comb begin
      ins         = '0;
      ins.valid   = id_valid & ~hazard & id_wr_en & (id_wr_reg != '0);
      ins.wr_reg  = REG_W_DEF'(id_wr_reg);
      ins.is_load = id_mem_rd;
   end

   hazard_scoreboard #(
      .LOAD_LAT (LOAD_LAT)
   ) u_sb (
      .clk    (clk),
      .rst    (rst),
      .freeze (freeze),
      .kill   (pipe_kill),
      .ins    (ins),
      .slots  (slots)
   );

   // Interlock cycles lost; frozen and killed cycles are not charged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (hazard && !freeze && !pipe_kill && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl at LOAD_LAT=1
// and LOAD_LAT=3 (the latter with a 4-bit counter to exercise saturation).
// Reference model: per-register "cycles until readable" tables for EX and ID.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid, id_use_rs, id_use_rt, id_branch, id_wr_en, id_mem_rd;
   logic [4:0] id_rs, id_rt, id_wr_reg;
   logic       dmem_busy, pipe_kill;

   logic        stall_pc1, stall_ifid1, flush1, freeze1;
   logic [15:0] cnt1;
   logic        stall_pc3, stall_ifid3, flush3, freeze3;
   logic [3:0]  cnt3;

   int tests = 0;
   int fails = 0;

   // Model: wex = unfrozen edges until an EX consumer may read, wid = same for a branch in ID.
   int wex [2][32];
   int wid [2][32];
   int mcnt[2];
   int lat_of[2] = '{1, 3};
   int cmax[2]   = '{65535, 15};

   always #5 clk = ~clk;

   hazard_ctrl #(.REG_W(5), .LOAD_LAT(1), .CNT_W(16)) u_dut1 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch(id_branch),
      .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg), .id_mem_rd(id_mem_rd),
      .dmem_busy(dmem_busy), .pipe_kill(pipe_kill), .stall_pc(stall_pc1),
      .stall_ifid(stall_ifid1), .flush_idex(flush1), .freeze(freeze1), .stall_cnt(cnt1)
   );

   hazard_ctrl #(.REG_W(5), .LOAD_LAT(3), .CNT_W(4)) u_dut3 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch(id_branch),
      .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg), .id_mem_rd(id_mem_rd),
      .dmem_busy(dmem_busy), .pipe_kill(pipe_kill), .stall_pc(stall_pc3),
      .stall_ifid(stall_ifid3), .flush_idex(flush3), .freeze(freeze3), .stall_cnt(cnt3)
   );

   function automatic logic mhaz(input int d);
      int w_rs, w_rt;
      if (!id_valid) return 1'b0;
      w_rs = id_branch ? wid[d][id_rs] : wex[d][id_rs];
      w_rt = id_branch ? wid[d][id_rt] : wex[d][id_rt];
      return (id_use_rs && id_rs != 0 && w_rs > 0) || (id_use_rt && id_rt != 0 && w_rt > 0);
   endfunction

   task automatic model_clear();
      for (int d = 0; d < 2; d++) begin
         for (int r = 0; r < 32; r++) begin
            wex[d][r] = 0;
            wid[d][r] = 0;
         end
         mcnt[d] = 0;
      end
   endtask

   task automatic set_id(input logic v, input int rs, input logic urs, input int rt,
                         input logic urt, input logic br, input logic we, input int wr,
                         input logic ld);
      id_valid  = v;    id_rs     = 5'(rs); id_use_rs = urs;
      id_rt     = 5'(rt); id_use_rt = urt;  id_branch = br;
      id_wr_en  = we;   id_wr_reg = 5'(wr); id_mem_rd = ld;
   endtask

   // Advance one clock and the model with it; called from the low phase.
   task automatic tick();
      logic h[2];
      int   l;
      h[0] = mhaz(0);
      h[1] = mhaz(1);
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         if (pipe_kill) begin
            for (int r = 0; r < 32; r++) begin wex[d][r] = 0; wid[d][r] = 0; end
         end else if (!dmem_busy) begin
            for (int r = 0; r < 32; r++) begin
               if (wex[d][r] > 0) wex[d][r]--;
               if (wid[d][r] > 0) wid[d][r]--;
            end
            if (id_valid && !h[d] && id_wr_en && id_wr_reg != 0) begin
               l = id_mem_rd ? lat_of[d] : 0;
               if (wex[d][id_wr_reg] < l)     wex[d][id_wr_reg] = l;
               if (wid[d][id_wr_reg] < l + 1) wid[d][id_wr_reg] = l + 1;
            end
         end
         if (h[d] && !dmem_busy && !pipe_kill) mcnt[d]++;
      end
      @(negedge clk);
   endtask

   task automatic apply_reset();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      dmem_busy = 1'b0;
      pipe_kill = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_clear();
   endtask

   // Hold the current ID instruction until both instances release it; count bubbles.
   task automatic count_stalls(input int busy_lo, input int busy_hi,
                               output int n1, output int n3, output int bad, output int frz_cnt);
      n1 = 0; n3 = 0; bad = 0; frz_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         dmem_busy = (k >= busy_lo) && (k <= busy_hi);
         #1;
         if (flush1) n1++;
         if (flush3) n3++;
         if (stall_ifid1 !== stall_pc1 || flush1 !== (stall_pc1 & ~freeze1) || freeze1 !== dmem_busy) bad++;
         if (stall_ifid3 !== stall_pc3 || flush3 !== (stall_pc3 & ~freeze3) || freeze3 !== dmem_busy) bad++;
         if (dmem_busy && (cnt1 != 0 || cnt3 != 0)) frz_cnt++;
         if (!stall_pc1 && !stall_pc3) break;
         tick();
      end
      dmem_busy = 1'b0;
   endtask

   task automatic test_reset();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      dmem_busy = 1'b0;
      pipe_kill = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      tests++;
      if ({stall_pc1, stall_ifid1, flush1, freeze1, stall_pc3, stall_ifid3, flush3, freeze3} !== 8'h00) begin
         fails++;
         $display("FAIL reset_outputs: got %b expected 00000000",
                  {stall_pc1, stall_ifid1, flush1, freeze1, stall_pc3, stall_ifid3, flush3, freeze3});
      end
      tests++;
      if (cnt1 !== 16'd0 || cnt3 !== 4'd0) begin
         fails++;
         $display("FAIL reset_cnt: got %0d/%0d expected 0/0", cnt1, cnt3);
      end
      dmem_busy = 1'b1;
      #1;
      tests++;
      if (freeze1 !== 1'b1 || freeze3 !== 1'b1) begin
         fails++;
         $display("FAIL reset_freeze: got %b%b expected 11", freeze1, freeze3);
      end
      dmem_busy = 1'b0;
      rst = 1'b0;
      model_clear();
      @(negedge clk);
   endtask

   task automatic test_load_use();
      int n1, n3, bad, fc;
      apply_reset();
      set_id(1, 1, 1, 2, 1, 0, 1, 8, 1);   // lw r8
      #1;
      tests++;
      if (stall_pc1 !== 1'b0 || stall_pc3 !== 1'b0) begin
         fails++;
         $display("FAIL load_issue: got %b%b expected 00", stall_pc1, stall_pc3);
      end
      tick();
      set_id(1, 8, 1, 1, 1, 0, 1, 9, 0);   // add r9,r8,r1
      count_stalls(-1, -1, n1, n3, bad, fc);
      tests++;
      if (n1 != 1 || n3 != 3) begin
         fails++;
         $display("FAIL load_use_len: got %0d/%0d expected 1/3", n1, n3);
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL load_use_outputs: got %0d inconsistent cycles expected 0", bad);
      end
      tests++;
      if (cnt1 !== 16'd1 || cnt3 !== 4'd3) begin
         fails++;
         $display("FAIL load_use_cnt: got %0d/%0d expected 1/3", cnt1, cnt3);
      end
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_branch();
      int n1, n3, bad, fc;
      apply_reset();
      set_id(1, 1, 1, 2, 1, 0, 1, 8, 0);   // add r8
      tick();
      set_id(1, 8, 1, 9, 1, 1, 0, 0, 0);   // beq r8,r9
      count_stalls(-1, -1, n1, n3, bad, fc);
      tests++;
      if (n1 != 1 || n3 != 1 || bad != 0) begin
         fails++;
         $display("FAIL alu_branch: got %0d/%0d bad=%0d expected 1/1 bad=0", n1, n3, bad);
      end
      apply_reset();
      set_id(1, 1, 1, 2, 1, 0, 1, 8, 1);   // lw r8
      tick();
      set_id(1, 8, 1, 0, 1, 1, 0, 0, 0);   // beq r8,r0
      count_stalls(-1, -1, n1, n3, bad, fc);
      tests++;
      if (n1 != 2 || n3 != 4 || bad != 0) begin
         fails++;
         $display("FAIL load_branch: got %0d/%0d bad=%0d expected 2/4 bad=0", n1, n3, bad);
      end
      tests++;
      if (cnt1 !== 16'd2 || cnt3 !== 4'd4) begin
         fails++;
         $display("FAIL load_branch_cnt: got %0d/%0d expected 2/4", cnt1, cnt3);
      end
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_no_stall();
      int n1, n3, bad, fc;
      int pwr[3] = '{8, 0, 8};
      int crs[3] = '{10, 0, 1};
      int crt[3] = '{1, 0, 8};
      logic curt[3] = '{1'b1, 1'b1, 1'b0};
      for (int c = 0; c < 3; c++) begin
         apply_reset();
         set_id(1, 1, 1, 2, 1, 0, 1, pwr[c], 1);
         tick();
         set_id(1, crs[c], 1, crt[c], curt[c], 0, 1, 9, 0);
         count_stalls(-1, -1, n1, n3, bad, fc);
         tests++;
         if (n1 != 0 || n3 != 0 || cnt1 !== 16'd0 || cnt3 !== 4'd0) begin
            fails++;
            $display("FAIL no_stall_case%0d: got %0d/%0d cnt %0d/%0d expected 0/0 cnt 0/0",
                     c, n1, n3, cnt1, cnt3);
         end
      end
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_freeze();
      int n1, n3, bad, fc;
      apply_reset();
      set_id(1, 1, 1, 2, 1, 0, 1, 8, 1);
      tick();
      set_id(1, 8, 1, 1, 1, 0, 1, 9, 0);
      count_stalls(0, 3, n1, n3, bad, fc);
      tests++;
      if (n1 != 1 || n3 != 3) begin
         fails++;
         $display("FAIL freeze_len: got %0d/%0d expected 1/3", n1, n3);
      end
      tests++;
      if (bad != 0 || fc != 0) begin
         fails++;
         $display("FAIL freeze_hold: got bad=%0d cnt_moves=%0d expected 0/0", bad, fc);
      end
      tests++;
      if (cnt1 !== 16'd1 || cnt3 !== 4'd3) begin
         fails++;
         $display("FAIL freeze_cnt: got %0d/%0d expected 1/3", cnt1, cnt3);
      end
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_kill();
      apply_reset();
      set_id(1, 1, 1, 2, 1, 0, 1, 8, 1);
      tick();
      set_id(1, 8, 1, 1, 1, 0, 1, 9, 0);
      pipe_kill = 1'b1;
      #1;
      tests++;
      if (stall_pc1 !== 1'b1 || stall_pc3 !== 1'b1 || flush1 !== 1'b1 || flush3 !== 1'b1) begin
         fails++;
         $display("FAIL kill_cycle: got %b%b%b%b expected 1111", stall_pc1, stall_pc3, flush1, flush3);
      end
      tick();
      pipe_kill = 1'b0;
      #1;
      tests++;
      if (stall_pc1 !== 1'b0 || stall_pc3 !== 1'b0) begin
         fails++;
         $display("FAIL kill_after: got %b%b expected 00", stall_pc1, stall_pc3);
      end
      tests++;
      if (cnt1 !== 16'd0 || cnt3 !== 4'd0) begin
         fails++;
         $display("FAIL kill_cnt: got %0d/%0d expected 0/0", cnt1, cnt3);
      end
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_async_reset();
      apply_reset();
      set_id(1, 1, 1, 2, 1, 0, 1, 8, 1);
      tick();
      set_id(1, 8, 1, 1, 1, 0, 1, 9, 0);
      tick();
      #1;
      tests++;
      if (stall_pc3 !== 1'b1 || cnt3 !== 4'd1 || cnt1 !== 16'd1) begin
         fails++;
         $display("FAIL pre_reset: got stall %b cnt %0d/%0d expected 1 cnt 1/1", stall_pc3, cnt1, cnt3);
      end
      rst = 1'b1;
      dmem_busy = 1'b1;
      #1;
      tests++;
      if ({stall_pc1, stall_ifid1, flush1, stall_pc3, stall_ifid3, flush3} !== 6'b0 ||
          freeze1 !== 1'b1 || freeze3 !== 1'b1) begin
         fails++;
         $display("FAIL async_reset_outputs: got %b freeze %b%b expected 000000 freeze 11",
                  {stall_pc1, stall_ifid1, flush1, stall_pc3, stall_ifid3, flush3}, freeze1, freeze3);
      end
      tests++;
      if (cnt1 !== 16'd0 || cnt3 !== 4'd0) begin
         fails++;
         $display("FAIL async_reset_cnt: got %0d/%0d expected 0/0", cnt1, cnt3);
      end
      #1;
      rst = 1'b0;
      dmem_busy = 1'b0;
      model_clear();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_random();
      logic hold;
      logic h;
      logic [3:0] got, exp;
      int ec;
      apply_reset();
      hold = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (!hold || $urandom_range(0, 3) == 0)
            set_id($urandom_range(0, 7) != 0,
                   $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                   $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                   $urandom_range(0, 3) == 0,
                   $urandom_range(0, 3) != 0, $urandom_range(0, 7),
                   $urandom_range(0, 9) < 3);
         dmem_busy = $urandom_range(0, 9) == 0;
         pipe_kill = $urandom_range(0, 29) == 0;
         #1;
         for (int d = 0; d < 2; d++) begin
            h   = mhaz(d);
            exp = {h, h, h & ~dmem_busy, dmem_busy};
            got = (d == 0) ? {stall_pc1, stall_ifid1, flush1, freeze1}
                           : {stall_pc3, stall_ifid3, flush3, freeze3};
            tests++;
            if (got !== exp) begin
               fails++;
               $display("FAIL rand_out_lat%0d cyc %0d: got %b expected %b", lat_of[d], cyc, got, exp);
            end
            ec = (mcnt[d] > cmax[d]) ? cmax[d] : mcnt[d];
            tests++;
            if (((d == 0) ? int'(cnt1) : int'(cnt3)) != ec) begin
               fails++;
               $display("FAIL rand_cnt_lat%0d cyc %0d: got %0d expected %0d",
                        lat_of[d], cyc, (d == 0) ? int'(cnt1) : int'(cnt3), ec);
            end
         end
         hold = mhaz(1);
         tick();
      end
      dmem_busy = 1'b0;
      pipe_kill = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
   endtask

   initial begin
      rst = 1'b1;
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      dmem_busy = 1'b0;
      pipe_kill = 1'b0;
      model_clear();
      @(negedge clk);
      test_reset();
      test_load_use();
      test_branch();
      test_no_stall();
      test_freeze();
      test_kill();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline interlock for the MIPS core. It replaces the single-cycle load-use comparator with a small issue-history scoreboard, so the stall length follows a configurable load latency. It also adds branch-in-ID operand interlocks, operand-use qualification, r0 exclusion, a data-memory freeze and a pipeline kill. It sits beside the ID stage and drives the PC, IF/ID and ID/EX control.

## Interface
- REG_W, 5, register-address width
- LOAD_LAT, 1, cycles (≥1) a load result is unavailable to an EX-stage consumer after the load enters EX
- CNT_W, 16, width of the stall performance counter
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  REG_W  source registers of ID instruction
- id_use_rs, id_use_rt  in  1  source actually read (compare only when set)
- id_branch  in  1  ID instruction is a branch resolved in ID (needs operands in ID)
- id_wr_en  in  1  ID instruction writes a register
- id_wr_reg  in  REG_W  its destination
- id_mem_rd  in  1  ID instruction is a load
- dmem_busy  in  1  data memory not ready; whole pipeline must hold
- pipe_kill  in  1  exception/redirect; discard all in-flight history
- stall_pc, stall_ifid  out  1  hold PC and IF/ID (identical value)
- flush_idex  out  1  insert bubble into ID/EX
- freeze  out  1  hold every pipeline register
- stall_cnt  out  CNT_W  cycles lost to interlock

## Operation
- Scoreboard: LOAD_LAT+1 slots; slot[i] describes the instruction i stages past EX entry (slot[0] = EX). Each slot holds valid, wr_reg, is_load.
- Shift each edge unless freeze. slot[0] receives the ID instruction when `id_valid & ~hazard & id_wr_en & id_wr_reg≠0`, else a bubble (valid=0). The oldest slot drops.
- lat(slot) = LOAD_LAT if is_load, else 0.
- src match: valid slot, wr_reg equals id_rs with id_use_rs, or equals id_rt with id_use_rt. Register 0 never matches.
- use_stall: non-branch ID instruction matches slot[i] with i < lat.
- br_stall: branch ID instruction matches slot[i] with i < lat+1.
- hazard = id_valid & (use_stall | br_stall).
- freeze = dmem_busy.
- stall_pc = stall_ifid = hazard.
- flush_idex = hazard & ~freeze. Freeze dominates: no bubble is injected while frozen.
- pipe_kill: all slots invalid at the next edge. It overrides both shift and insert, and wins over a simultaneous issue. Outputs in the kill cycle still reflect the current slots.
- stall_cnt: +1 on each edge with hazard & ~freeze & ~pipe_kill. Saturates at all-ones and does not wrap.

## Timing
- All outputs are combinational from current inputs and slot state (zero latency). State updates only on posedge clk.
- rst asserted, including mid-stall: all slots invalid and stall_cnt = 0 immediately. stall_pc/stall_ifid/flush_idex = 0 unless driven by current inputs; freeze follows dmem_busy.
- Load followed directly by a consumer: exactly LOAD_LAT stall cycles.
- Non-load producer followed by a branch: 1 stall cycle.
- Load followed by a branch: LOAD_LAT+1 stall cycles.
- Any dmem_busy cycles extend the wall-clock length but not the stall count.
- One producer matching both rs and rt counts once. With two producers, the stall lasts until the longer requirement clears.

## Structure
- Shared package hazard_pkg holds:
  - REG_W default
  - slot typedef {valid, wr_reg, is_load}
  - LOAD_LAT default
- Sub-module hazard_scoreboard (slot shift register, kill, freeze hold) is natural. The comparators, outputs and counter stay in hazard_ctrl.

## Test plan
- LOAD_LAT=1: lw r8 issues, then add r9,r8,r1 in ID → hazard/flush_idex high 1 cycle, add issues next cycle, stall_cnt=1.
- LOAD_LAT=3: same sequence → 3 stall cycles, stall_cnt=3. Unrelated source r10 → 0 stalls.
- add r8 then beq r8,r9 → 1 stall. lw r8 then beq r8,r0 → LOAD_LAT+1 stalls.
- lw r0 then add using r0 → no stall. lw r8 then instruction with id_use_rt=0, id_rt=8 → no stall.
- lw r8, consumer in ID, dmem_busy high 4 cycles mid-stall → freeze=1 and flush_idex=0 during busy. Total interlock cycles still LOAD_LAT. Counter unchanged while frozen.
- lw r8, pipe_kill on next cycle with consumer in ID → stall visible in the kill cycle only, then 0. Async rst mid-stall → outputs drop and stall_cnt=0 before the next edge.
